// File: rtl/eeg_xram_rd_seq.sv
// Strided single-word read sequencer for one XRAM lane, with a credit-managed output FIFO.
// Optional overflow checker: define EEG_XRAM_RD_SEQ_OVF_CHK_EN to build the sticky OVF_ERR logic.
module eeg_xram_rd_seq #(
    parameter int ADD_AW  = 12,
    parameter int DAT_DW  = 8,
    parameter int LEN_DW  = 12,
    parameter int FIFO_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CFG_VLD,
    output logic              CFG_RDY,
    input  logic [ADD_AW-1:0] CFG_BASE,
    input  logic [ADD_AW-1:0] CFG_STRIDE,
    input  logic [LEN_DW-1:0] CFG_LEN,
    output logic              XRAM_ADD_VLD,
    output logic              XRAM_ADD_LST,
    input  logic              XRAM_ADD_RDY,
    output logic [ADD_AW-1:0] XRAM_ADD_ADD,
    input  logic              XRAM_DAT_VLD,
    input  logic              XRAM_DAT_LST,
    output logic              XRAM_DAT_RDY,
    input  logic [DAT_DW-1:0] XRAM_DAT_DAT,
    output logic              OUT_VLD,
    output logic              OUT_LST,
    input  logic              OUT_RDY,
    output logic [DAT_DW-1:0] OUT_DAT,
    output logic              BUSY,
    output logic              OVF_ERR
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = FIFO_AW + 1;
    localparam logic [CNT_W:0] CRED_LIM = (CNT_W + 1)'(DEPTH - 1);

    // Handshake rule on every channel: a transfer happens on a rising edge where VLD and RDY are both high.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADD_AW-1:0] addr_q, addr_d;
    logic [ADD_AW-1:0] stride_q, stride_d;
    logic [LEN_DW-1:0] rem_q, rem_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] rptr_q, rptr_d;
    logic [DAT_DW:0]   mem_q [DEPTH];
    logic [DAT_DW:0]   mem_d [DEPTH];

    logic [CNT_W:0]    occ;
    logic              credit_ok;
    logic              add_vld;
    logic              add_hs;
    logic              out_vld;
    logic              pop;
    logic              push_req;
    logic              push;
    logic [DAT_DW:0]   head;

`ifdef EEG_XRAM_RD_SEQ_OVF_CHK_EN
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    logic ovf_q, ovf_d;
    logic full;
`endif

    // Credits count the word already on the data channel, so one slot is always free for it.
    always_comb begin
        occ       = {1'b0, fifo_cnt_q} + {{CNT_W{1'b0}}, inflight_q};
        credit_ok = (occ < CRED_LIM);
        add_vld   = (state_q == S_ISSUE) && credit_ok;
        add_hs    = add_vld && XRAM_ADD_RDY;
        out_vld   = (fifo_cnt_q != '0);
        head      = mem_q[rptr_q];
        pop       = out_vld && OUT_RDY;
        push_req  = XRAM_DAT_VLD && inflight_q;
`ifdef EEG_XRAM_RD_SEQ_OVF_CHK_EN
        full      = (fifo_cnt_q == FULL_CNT);
        push      = push_req && !(full && !pop);
        ovf_d     = ovf_q || (push_req && full && !pop);
`else
        push      = push_req;
`endif
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        stride_d   = stride_q;
        rem_d      = rem_q;
        inflight_d = add_hs;
        case (state_q)
            S_IDLE: begin
                if (CFG_VLD) begin
                    addr_d   = CFG_BASE;
                    stride_d = CFG_STRIDE;
                    rem_d    = CFG_LEN;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (add_hs) begin
                    addr_d = addr_q + stride_q;
                    rem_d  = rem_q - LEN_DW'(1);
                    if (rem_q == '0) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && head[DAT_DW]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_d      = mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            mem_d[wptr_q] = {XRAM_DAT_LST, XRAM_DAT_DAT};
            wptr_d        = wptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + FIFO_AW'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            stride_q   <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            fifo_cnt_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef EEG_XRAM_RD_SEQ_OVF_CHK_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            stride_q   <= stride_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            mem_q      <= mem_d;
`ifdef EEG_XRAM_RD_SEQ_OVF_CHK_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign CFG_RDY      = (state_q == S_IDLE);
    assign XRAM_ADD_VLD = add_vld;
    assign XRAM_ADD_LST = (state_q == S_ISSUE) && (rem_q == '0);
    assign XRAM_ADD_ADD = addr_q;
    assign XRAM_DAT_RDY = 1'b1;
    assign OUT_VLD      = out_vld;
    assign OUT_LST      = head[DAT_DW];
    assign OUT_DAT      = head[DAT_DW-1:0];
    assign BUSY         = (state_q != S_IDLE);
`ifdef EEG_XRAM_RD_SEQ_OVF_CHK_EN
    assign OVF_ERR      = ovf_q;
`else
    assign OVF_ERR      = 1'b0;
`endif

endmodule

// File: tb/tb_eeg_xram_rd_seq.sv
// Scoreboard bench for eeg_xram_rd_seq: an XRAM lane model answers addresses, monitors pop expected queues.
module tb_eeg_xram_rd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        CFG_VLD, CFG_RDY;
    logic [11:0] CFG_BASE, CFG_STRIDE, CFG_LEN;
    logic        XRAM_ADD_VLD, XRAM_ADD_LST, XRAM_ADD_RDY;
    logic [11:0] XRAM_ADD_ADD;
    logic        XRAM_DAT_VLD, XRAM_DAT_LST, XRAM_DAT_RDY;
    logic [7:0]  XRAM_DAT_DAT;
    logic        OUT_VLD, OUT_LST, OUT_RDY;
    logic [7:0]  OUT_DAT;
    logic        BUSY, OVF_ERR;

    int total = 0;
    int bad   = 0;
    int addr_hs = 0;
    int pops    = 0;
    logic [12:0] exp_a_q[$];
    logic [8:0]  exp_q[$];

    logic        hs_n = 1'b0;
    logic [11:0] ha = '0;
    logic        hl = 1'b0;
    logic        inj = 1'b0;
    logic        add_rdy_mode = 1'b0;

    eeg_xram_rd_seq #(.ADD_AW(12), .DAT_DW(8), .LEN_DW(12), .FIFO_AW(2)) dut (
        .clk(clk), .rst(rst),
        .CFG_VLD(CFG_VLD), .CFG_RDY(CFG_RDY), .CFG_BASE(CFG_BASE),
        .CFG_STRIDE(CFG_STRIDE), .CFG_LEN(CFG_LEN),
        .XRAM_ADD_VLD(XRAM_ADD_VLD), .XRAM_ADD_LST(XRAM_ADD_LST),
        .XRAM_ADD_RDY(XRAM_ADD_RDY), .XRAM_ADD_ADD(XRAM_ADD_ADD),
        .XRAM_DAT_VLD(XRAM_DAT_VLD), .XRAM_DAT_LST(XRAM_DAT_LST),
        .XRAM_DAT_RDY(XRAM_DAT_RDY), .XRAM_DAT_DAT(XRAM_DAT_DAT),
        .OUT_VLD(OUT_VLD), .OUT_LST(OUT_LST), .OUT_RDY(OUT_RDY), .OUT_DAT(OUT_DAT),
        .BUSY(BUSY), .OVF_ERR(OVF_ERR)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_val(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic flush_sb();
        exp_q.delete();
        exp_a_q.delete();
        addr_hs = 0;
        pops    = 0;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_cfg_rdy"},  32'(CFG_RDY), 32'd1);
        check({tag, "_add_vld"},  32'(XRAM_ADD_VLD), 32'd0);
        check({tag, "_add_lst"},  32'(XRAM_ADD_LST), 32'd0);
        check({tag, "_add_add"},  32'(XRAM_ADD_ADD), 32'd0);
        check({tag, "_dat_rdy"},  32'(XRAM_DAT_RDY), 32'd1);
        check({tag, "_out_vld"},  32'(OUT_VLD), 32'd0);
        check({tag, "_out_lst"},  32'(OUT_LST), 32'd0);
        check({tag, "_out_dat"},  32'(OUT_DAT), 32'd0);
        check({tag, "_busy"},     32'(BUSY), 32'd0);
        check({tag, "_ovf_err"},  32'(OVF_ERR), 32'd0);
    endtask

    // driver: waits for CFG_RDY, queues the expected addresses and data, then presents one descriptor
    task automatic send_desc(input logic [11:0] base, input logic [11:0] stride, input logic [11:0] len);
        int guard = 0;
        while (!CFG_RDY && guard < 200) begin
            step();
            guard++;
        end
        check("cfg_rdy_wait", 32'(guard < 200), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            logic [11:0] a;
            a = 12'(base + 12'(i) * stride);
            exp_a_q.push_back({(i == int'(len)), a});
            exp_q.push_back({(i == int'(len)), mem_val(a)});
        end
        CFG_VLD    = 1'b1;
        CFG_BASE   = base;
        CFG_STRIDE = stride;
        CFG_LEN    = len;
        step();
        CFG_VLD    = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while ((BUSY || exp_q.size() != 0 || exp_a_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_done"}, 32'(n < budget), 32'd1);
    endtask

    // address/output monitor: one handshake per channel per cycle, sampled mid-cycle
    always @(negedge clk) begin
        logic [12:0] ea;
        logic [8:0]  ed;
        hs_n = 1'b0;
        if (!rst) begin
            if (XRAM_ADD_VLD && XRAM_ADD_RDY) begin
                hs_n = 1'b1;
                ha   = XRAM_ADD_ADD;
                hl   = XRAM_ADD_LST;
                addr_hs++;
                if (exp_a_q.size() == 0) begin
                    check("addr_unexpected", 32'(XRAM_ADD_ADD), 32'hFFFF_FFFF);
                end else begin
                    ea = exp_a_q.pop_front();
                    check("xram_addr", 32'(XRAM_ADD_ADD), 32'(ea[11:0]));
                    check("xram_add_lst", 32'(XRAM_ADD_LST), 32'(ea[12]));
                end
            end
            if (OUT_VLD && OUT_RDY) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 32'(OUT_DAT), 32'hFFFF_FFFF);
                end else begin
                    ed = exp_q.pop_front();
                    check("out_dat", 32'(OUT_DAT), 32'(ed[7:0]));
                    check("out_lst", 32'(OUT_LST), 32'(ed[8]));
                end
            end
        end
    end

    // XRAM lane model: data returns one cycle after each accepted address
    always @(posedge clk) begin
        #1;
        XRAM_DAT_VLD = hs_n | inj;
        XRAM_DAT_DAT = hs_n ? mem_val(ha) : 8'hEE;
        XRAM_DAT_LST = hs_n & hl;
        XRAM_ADD_RDY = add_rdy_mode ? ~XRAM_ADD_RDY : 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        CFG_VLD = 1'b0; CFG_BASE = '0; CFG_STRIDE = '0; CFG_LEN = '0;
        OUT_RDY = 1'b0;
        XRAM_DAT_VLD = 1'b0; XRAM_DAT_DAT = '0; XRAM_DAT_LST = 1'b0; XRAM_ADD_RDY = 1'b1;
        repeat (2) step();
        sample();
        chk_reset("reset");
        step();
        rst = 1'b0;
        step();

        // basic burst with latency and BUSY-after-last-pop checks
        OUT_RDY = 1'b1;
        send_desc(12'h010, 12'd1, 12'd3);
        sample();
        check("lat_add_vld_c1", 32'(XRAM_ADD_VLD), 32'd1);
        check("lat_add_addr_c1", 32'(XRAM_ADD_ADD), 32'h010);
        step(); sample();
        check("lat_out_vld_c2", 32'(OUT_VLD), 32'd0);
        step(); sample();
        check("lat_out_vld_c3", 32'(OUT_VLD), 32'd1);
        n = 0;
        while (!(OUT_VLD && OUT_RDY && OUT_LST) && n < 50) begin
            step(); sample();
            n++;
        end
        check("basic_last_seen", 32'(n < 50), 32'd1);
        check("basic_busy_at_last", 32'(BUSY), 32'd1);
        step(); sample();
        check("basic_busy_after", 32'(BUSY), 32'd0);
        check("basic_cfg_rdy_after", 32'(CFG_RDY), 32'd1);
        check("basic_drained", 32'(exp_q.size()), 32'd0);
        step();

        // wrap-around with a stuttering address ready
        add_rdy_mode = 1'b1;
        send_desc(12'hFFE, 12'd3, 12'd2);
        wait_idle(100, "wrap");
        add_rdy_mode = 1'b0;
        step();

        // back-pressure
        OUT_RDY = 1'b0;
        send_desc(12'h200, 12'd1, 12'd15);
        repeat (20) begin
            sample();
            check("bp_outstanding_le3", 32'((addr_hs - pops) <= 3), 32'd1);
            step();
        end
        sample();
        check("bp_add_vld_stalled", 32'(XRAM_ADD_VLD), 32'd0);
        check("bp_outstanding", 32'(addr_hs - pops), 32'd3);
        check("bp_out_vld", 32'(OUT_VLD), 32'd1);
        check("bp_ovf_mid", 32'(OVF_ERR), 32'd0);
        step();
        OUT_RDY = 1'b1;
        wait_idle(200, "bp");
        check("bp_ovf_end", 32'(OVF_ERR), 32'd0);

        // single word and busy rejection
        send_desc(12'h3A5, 12'd5, 12'd0);
        CFG_VLD = 1'b1; CFG_BASE = 12'h777; CFG_STRIDE = 12'd1; CFG_LEN = 12'd4;
        sample();
        check("busy_cfg_rdy", 32'(CFG_RDY), 32'd0);
        check("busy_busy", 32'(BUSY), 32'd1);
        step();
        CFG_VLD = 1'b0;
        wait_idle(50, "single");
        repeat (4) step();
        check("single_idle", 32'(BUSY), 32'd0);
        check("single_balance", 32'(addr_hs - pops), 32'd0);

        // reset during word 5 of a 10-word burst
        begin
            int p0;
            p0 = pops;
            send_desc(12'h050, 12'd1, 12'd9);
            n = 0;
            while ((pops - p0) < 4 && n < 50) begin
                step();
                n++;
            end
            check("mid_rst_reach_w5", 32'(n < 50), 32'd1);
        end
        rst = 1'b1;
        sample();
        inj = 1'b1;
        step();
        rst = 1'b0;
        flush_sb();
        sample();
        chk_reset("mid_rst");
        inj = 1'b0;
        step(); sample();
        check("stale_dropped_out_vld", 32'(OUT_VLD), 32'd0);
        check("stale_dropped_busy", 32'(BUSY), 32'd0);
        step();
        send_desc(12'h0F0, 12'h010, 12'd2);
        wait_idle(50, "post_rst");

`ifdef EEG_XRAM_RD_SEQ_OVF_CHK_EN
        OUT_RDY = 1'b0;
        send_desc(12'h300, 12'd1, 12'd7);
        repeat (10) step();
        check("ovf_pre", 32'(OVF_ERR), 32'd0);
        force dut.inflight_q = 1'b1;
        sample();
        inj = 1'b1;
        repeat (3) step();
        sample();
        check("ovf_set", 32'(OVF_ERR), 32'd1);
        inj = 1'b0;
        step();
        release dut.inflight_q;
        repeat (3) step();
        check("ovf_sticky", 32'(OVF_ERR), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        flush_sb();
        sample();
        check("ovf_cleared", 32'(OVF_ERR), 32'd0);
        step();
        OUT_RDY = 1'b1;
`endif

        repeat (3) step();
        check("final_exp_empty", 32'(exp_q.size()), 32'd0);
        check("final_addr_empty", 32'(exp_a_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
